// File: rtl/interleaver_ram_if.sv
// Bus between the interleaver sequencer, the encoder side, the external RAM and the mapper.
// Master is the sequencer; slave is everything around it.
interface interleaver_ram_if;
  logic [1:0] mod_sel;
  logic       bit_i;
  logic       bit_valid;
  logic       bit_ready;
  logic [9:0] ram_waddr;
  logic       ram_wen;
  logic       ram_wdata;
  logic [6:0] ram_raddr;
  logic [5:0] ram_rdata;
  logic       sc_valid;
  logic       sc_ready;
  logic [5:0] sc_data;
  logic [5:0] sc_idx;
  logic       sc_last;
  logic [1:0] bank_full;

  modport master (
    input  mod_sel, bit_i, bit_valid, ram_rdata, sc_ready,
    output bit_ready, ram_waddr, ram_wen, ram_wdata, ram_raddr,
           sc_valid, sc_data, sc_idx, sc_last, bank_full
  );

  modport slave (
    output mod_sel, bit_i, bit_valid, ram_rdata, sc_ready,
    input  bit_ready, ram_waddr, ram_wen, ram_wdata, ram_raddr,
           sc_valid, sc_data, sc_idx, sc_last, bank_full
  );
endinterface

// File: rtl/interleaver_ram_ctrl.sv
// Ping-pong write/read sequencer for the TX first-permutation interleaver RAM.
// Bits are written column-wise into bit-addressed words; words are read out row-wise.
module interleaver_ram_ctrl #(
  parameter int DEPTH = 128
) (
  input logic             clk,
  input logic             rstn,
  interleaver_ram_if.master bus
);

  localparam int SC_W = $clog2(DEPTH / 2);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(47);

  function automatic logic [2:0] nbpsc(input logic [1:0] m);
    case (m)
      2'd0:    nbpsc = 3'd1;
      2'd1:    nbpsc = 3'd2;
      2'd2:    nbpsc = 3'd4;
      default: nbpsc = 3'd6;
    endcase
  endfunction

  function automatic logic [5:0] bit_mask(input logic [1:0] m);
    case (m)
      2'd0:    bit_mask = 6'b000001;
      2'd1:    bit_mask = 6'b000011;
      2'd2:    bit_mask = 6'b001111;
      default: bit_mask = 6'b111111;
    endcase
  endfunction

  logic [1:0]      bank_full;
  logic [1:0]      bank_full_nxt;
  logic            wbank;
  logic            rbank;
  logic [3:0]      row;
  logic [1:0]      colq;
  logic [2:0]      colr;
  logic [1:0]      mod_r [2];
  logic [SC_W-1:0] rsc;

  logic            sym_start;
  logic [1:0]      wmod;
  logic [2:0]      colr_max;
  logic [5:0]      wsc;
  logic            wr_fire;
  logic            wr_end;
  logic            rd_fire;
  logic            rd_end;

  // The first bit of a symbol still sees the live mod_sel, before it is latched.
  assign sym_start = (row == 4'd0) && (colq == 2'd0) && (colr == 3'd0);
  assign wmod      = sym_start ? bus.mod_sel : mod_r[wbank];
  assign colr_max  = nbpsc(wmod) - 3'd1;
  assign wsc       = ({2'b00, row} * 6'd3) + {4'b0000, colq};

  assign bus.bit_ready = rstn & ~bank_full[wbank];
  assign wr_fire       = bus.bit_valid & bus.bit_ready;
  assign wr_end        = wr_fire && (row == 4'd15) && (colq == 2'd2) && (colr == colr_max);

  assign bus.ram_wen   = wr_fire;
  assign bus.ram_wdata = bus.bit_i;
  assign bus.ram_waddr = {wbank, wsc, colr};

  assign bus.sc_valid  = bank_full[rbank];
  assign rd_fire       = bus.sc_valid & bus.sc_ready;
  assign rd_end        = rd_fire && (rsc == SC_LAST);

  assign bus.ram_raddr = {rbank, rsc};
  assign bus.sc_idx    = rsc;
  assign bus.sc_last   = (rsc == SC_LAST);
  // Upper bits may be left over from an earlier, denser symbol in this bank.
  assign bus.sc_data   = bus.ram_rdata & bit_mask(mod_r[rbank]);
  assign bus.bank_full = bank_full;

  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_end) bank_full_nxt[wbank] = 1'b1;
    if (rd_end) bank_full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full <= 2'b00;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      row       <= 4'd0;
      colq      <= 2'd0;
      colr      <= 3'd0;
      mod_r[0]  <= 2'd0;
      mod_r[1]  <= 2'd0;
      rsc       <= '0;
    end else begin
      bank_full <= bank_full_nxt;

      if (wr_fire) begin
        if (sym_start) mod_r[wbank] <= bus.mod_sel;
        if (wr_end) begin
          row   <= 4'd0;
          colq  <= 2'd0;
          colr  <= 3'd0;
          wbank <= ~wbank;
        end else begin
          row <= row + 4'd1;
          if (row == 4'd15) begin
            if (colr == colr_max) begin
              colr <= 3'd0;
              colq <= colq + 2'd1;
            end else begin
              colr <= colr + 3'd1;
            end
          end
        end
      end

      if (rd_fire) begin
        if (rd_end) begin
          rsc   <= '0;
          rbank <= ~rbank;
        end else begin
          rsc <= rsc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaver_ram_ctrl.sv
// Directed self-checking bench for interleaver_ram_ctrl with a behavioural bit-write RAM.
module tb_interleaver_ram_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  interleaver_ram_if bus();

  interleaver_ram_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [5:0] mem [128] = '{default: 6'd0};
  always @(posedge clk)
    if (bus.ram_wen) mem[bus.ram_waddr[9:3]][bus.ram_waddr[2:0]] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_raddr];

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] rd_data [48];
  logic [5:0] rd_idx  [48];
  logic       rd_last [48];

  logic [287:0] bits, p1, p2, p3, pa, pb, pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] m);
    case (m)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  // Inverse mapping: bit b of word sc came from input bit k = 16*(colq*N + b) + row.
  function automatic logic [5:0] exp_word(input logic [287:0] v, input logic [1:0] m, input int sc);
    int row;
    int cq;
    logic [5:0] w;
    row = sc / 3;
    cq  = sc % 3;
    w   = 6'd0;
    for (int b = 0; b < nb(m); b++) w[b] = v[16 * (cq * nb(m) + b) + row];
    return w;
  endfunction

  task automatic send_bits(input logic [1:0] m, input logic [287:0] v, input int n);
    int k;
    int guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < n && guard < 2000) begin
      @(negedge clk);
      bus.bit_valid = 1'b1;
      bus.bit_i     = v[k];
      bus.mod_sel   = m;
      acc           = bus.bit_ready;
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    #1 bus.bit_valid = 1'b0;
    check("send_count", k, n);
  endtask

  task automatic read_sym();
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < 48 && guard < 2000) begin
      @(negedge clk);
      bus.sc_ready = 1'b1;
      if (bus.sc_valid) begin
        rd_data[n] = bus.sc_data;
        rd_idx[n]  = bus.sc_idx;
        rd_last[n] = bus.sc_last;
        n++;
      end
      @(posedge clk);
      guard++;
    end
    #1 bus.sc_ready = 1'b0;
    check("read_count", n, 48);
  endtask

  task automatic verify_sym(input string tag, input logic [287:0] v, input logic [1:0] m);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(rd_data[i]), 32'(exp_word(v, m, i)));
      check($sformatf("%s_idx%0d", tag, i), 32'(rd_idx[i]), i);
      check($sformatf("%s_last%0d", tag, i), 32'(rd_last[i]), (i == 47) ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn          = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sc_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_i     = 1'b0;
    bus.mod_sel   = 2'd0;
    bus.sc_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bank_full", 32'(bus.bank_full), 0);
    check("rst_sc_valid", 32'(bus.sc_valid), 0);
    check("rst_sc_last", 32'(bus.sc_last), 0);
    check("rst_sc_idx", 32'(bus.sc_idx), 0);
    check("rst_ram_wen", 32'(bus.ram_wen), 0);
    rstn = 1'b1;
    #1 check("rst_bit_ready", 32'(bus.bit_ready), 1);

    // BPSK, single bit k=1 -> sc 3 bit 0
    bits = '0; bits[1] = 1'b1;
    send_bits(2'd0, bits, 48);
    @(negedge clk);
    check("t1_latency_valid", 32'(bus.sc_valid), 1);
    check("t1_bank_full", 32'(bus.bank_full), 32'b01);
    read_sym();
    verify_sym("t1", bits, 2'd0);
    check("t1_sc3", 32'(rd_data[3]), 32'b000001);
    @(negedge clk);
    check("t1_valid_after", 32'(bus.sc_valid), 0);

    // QPSK, k=17 -> sc 3 bit 1
    do_reset();
    bits = '0; bits[17] = 1'b1;
    send_bits(2'd1, bits, 96);
    @(negedge clk);
    check("t2_full_before", 32'(bus.bank_full), 32'b01);
    read_sym();
    verify_sym("t2", bits, 2'd1);
    check("t2_sc3", 32'(rd_data[3]), 32'b000010);
    @(negedge clk);
    check("t2_full_after", 32'(bus.bank_full), 32'b00);

    // 64QAM, k=15,16,287
    do_reset();
    bits = '0; bits[15] = 1'b1; bits[16] = 1'b1; bits[287] = 1'b1;
    send_bits(2'd3, bits, 288);
    read_sym();
    verify_sym("t3", bits, 2'd3);
    check("t3_sc45", 32'(rd_data[45]), 32'b000001);
    check("t3_sc0", 32'(rd_data[0]), 32'b000010);
    check("t3_sc47", 32'(rd_data[47]), 32'b100000);

    // 64QAM all ones, then BPSK zeros over the same bank: stale bits must be masked
    do_reset();
    bits = '1;
    send_bits(2'd3, bits, 288);
    read_sym();
    check("t4_ones20", 32'(rd_data[20]), 32'h3F);
    do_reset();
    bits = '0;
    send_bits(2'd0, bits, 48);
    read_sym();
    verify_sym("t4_mask", bits, 2'd0);

    // Back-pressure across three BPSK symbols
    do_reset();
    p1 = '0; p1[47:0] = 48'hA5C3_0F1E_9B27;
    p2 = '0; p2[47:0] = 48'h1234_5678_9ABC;
    p3 = '0; p3[47:0] = 48'hF0F0_3C3C_6969;
    send_bits(2'd0, p1, 48);
    send_bits(2'd0, p2, 48);
    @(negedge clk);
    check("t5_full", 32'(bus.bank_full), 32'b11);
    check("t5_ready_low", 32'(bus.bit_ready), 0);
    check("t5_valid", 32'(bus.sc_valid), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_hold_idx", 32'(bus.sc_idx), 0);
      check("t5_hold_data", 32'(bus.sc_data), 32'(exp_word(p1, 2'd0, 0)));
    end
    fork
      send_bits(2'd0, p3, 48);
      begin
        read_sym();
        check("t5_ready_back", 32'(bus.bit_ready), 1);
        verify_sym("t5a", p1, 2'd0);
        read_sym();
        verify_sym("t5b", p2, 2'd0);
        read_sym();
        verify_sym("t5c", p3, 2'd0);
      end
    join

    // Reset in the middle of a 64QAM symbol while bank 0 holds a full symbol
    do_reset();
    pa = '0; pa[47:0] = 48'hFFFF_0000_FFFF;
    pb = '1;
    send_bits(2'd0, pa, 48);
    send_bits(2'd3, pb, 100);
    @(negedge clk);
    check("t6_full_pre", 32'(bus.bank_full), 32'b01);
    rstn = 1'b0;
    #1;
    check("t6_full_rst", 32'(bus.bank_full), 0);
    check("t6_valid_rst", 32'(bus.sc_valid), 0);
    check("t6_wen_rst", 32'(bus.ram_wen), 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t6_ready", 32'(bus.bit_ready), 1);
    check("t6_idx", 32'(bus.sc_idx), 0);
    pc = '0; pc[47:0] = 48'h0F0F_A5A5_3333;
    send_bits(2'd0, pc, 48);
    read_sym();
    verify_sym("t6", pc, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interleaver_ram_ctrl.md
# interleaver_ram_ctrl

Write/read sequencer for the bit-serial-in, 6-bit-parallel-out TX interleaver RAM. It accepts encoded bits one per cycle and scatters them into a ping-pong pair of 64-word banks using the 802.11a/g first interleaver permutation (column write, row read). It then streams one up-to-6-bit subcarrier word per handshake to the mapper. The block sits between the convolutional encoder/puncturer and the constellation mapper. It drives the RAM's write port and read address; the RAM itself stays external.

## Interface
- DEPTH, 128, RAM word count. Fixed at 128: two banks of 64 words, bank select is the MSB of the word address.
- clk  in  1  system clock
- rstn  in  1  reset; **one clock; reset is asynchronous and active-low**
- mod_sel  in  2  modulation: 0 BPSK (N_BPSC=1), 1 QPSK (2), 2 16QAM (4), 3 64QAM (6)
- bit_i  in  1  encoded bit
- bit_valid  in  1  bit_i valid
- bit_ready  out  1  bit accepted when bit_valid & bit_ready
- ram_waddr  out  10  bit address {wbank, sc[5:0], b[2:0]}
- ram_wen  out  1  RAM write enable
- ram_wdata  out  1  RAM write data (= bit_i)
- ram_raddr  out  7  word address {rbank, rsc[5:0]}
- ram_rdata  in  6  RAM read data (combinational read)
- sc_valid  out  1  subcarrier word valid
- sc_ready  in  1  mapper accepts
- sc_data  out  6  ram_rdata with bits ≥ N_BPSC forced to 0
- sc_idx  out  6  subcarrier index 0..47
- sc_last  out  1  high with sc_idx==47
- bank_full  out  2  per-bank full flags

## Operation
- Symbol size: N_CBPS = 48·N_BPSC bits. Incoming bit k is tracked as row = k mod 16 (4 bits) and col = k/16, with col kept as a quotient/remainder pair (colq 0..2, colr 0..N_BPSC-1).
- Address mapping:
  - Permuted index i = 3·N_BPSC·row + col.
  - Subcarrier sc = 3·row + colq; bit position b = colr.
  - Address arithmetic needs no divider: row increments each bit. When row wraps 15→0, colr increments; when colr reaches N_BPSC-1 it wraps to 0 and colq increments.
- End of symbol: reached on the bit accepted with row=15, colq=2, colr=N_BPSC-1. On that acceptance:
  - set bank_full[wbank];
  - toggle wbank;
  - clear row/colq/colr.
- Mod latching: mod_sel is sampled into mod_r[wbank] on the first accepted bit of a symbol (all counters zero). It is ignored for the rest of that symbol.
- Write handshake:
  - bit_ready = !bank_full[wbank].
  - ram_wen = bit_valid & bit_ready.
  - ram_waddr and ram_wdata are combinational from the counters and bit_i.
- Read side:
  - sc_valid = bank_full[rbank].
  - ram_raddr = {rbank, rsc}; sc_idx = rsc.
  - sc_data masks ram_rdata using mod_r[rbank]. This masking removes stale bits left by a previous symbol that used a higher modulation.
  - On each handshake rsc increments. On the handshake with rsc==47: clear bank_full[rbank], toggle rbank, set rsc to 0.
- Second permutation (bit rotation within 16/64QAM words) is not done here; it belongs to the mapper.
- Simultaneous set of one bank's full flag and clear of the other is legal and both take effect. Set and clear of the same bank in one cycle cannot occur.
- RAM contents are never cleared by this block.

## Timing
- Reset values:
  - bank_full=00, wbank=rbank=0, all counters 0, mod_r=0;
  - sc_valid=0, sc_last=0, sc_idx=0, ram_wen=0;
  - bit_ready=1 as soon as rstn deasserts.
- Reset mid-operation discards any partial or full symbols. Output resumes only after 48·N_BPSC new bits.
- Write throughput is one bit per cycle while a bank is free. Read throughput is one word per cycle.
- Latency: last bit of a symbol accepted at edge t → sc_valid=1 in cycle t+1 (if rbank is that bank). ram_rdata is already valid, because the write landed at edge t.
- While sc_valid & !sc_ready, ram_raddr, sc_data, sc_idx and sc_last hold stable.
- When both banks are full, bit_ready=0. It returns to 1 in the cycle after the sc_last handshake.

## Test plan
- BPSK, 48 bits with only k=1 set → exactly one word nonzero: sc_idx=3 → sc_data=000001. All other words 0. sc_last on word 47.
- QPSK, 96 bits with only k=17 set → sc_idx=3 sc_data=000010. bank_full toggles 01→00 across the read.
- 64QAM, 288 bits with k=15, 16 and 287 set →
  - sc 45 = 000001
  - sc 0 = 000010
  - sc 47 = 100000
- 64QAM all-ones symbol followed by BPSK all-zeros in the same bank → every BPSK word reads 000000 (masking).
- sc_ready=0 held while three symbols are streamed → bit_ready drops after the second symbol. The first word holds sc_idx=0. Releasing sc_ready drains 96 words in order, with no loss.
- rstn pulsed low mid-symbol (bit 100 of 64QAM) → bank_full=00 and sc_valid=0 immediately. A fresh BPSK symbol then reads correctly from bank 0.
